load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-side counterpart of the execute stage: consumes the effective address (the ALU_result of lb/lh/lw/sb/sh/sw/lbu/lhu) and the rt store data.
- Performs one request/ready transaction on a 32-bit word-addressed data memory port.
- Handles big-endian byte/halfword lane steering, load extension and alignment checks.
- Reports completion or error with a one-cycle done pulse.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in REQ waiting for mem_ready before aborting; 0 disables timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  request strobe; sampled only in IDLE
opcode  in  6  MIPS opcode of the memory instruction
addr  in  32  effective byte address (from ALU)
store_data  in  32  rt register value
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_wstrb  out  4  byte enables; bit3 = bits 31:24 = byte offset 0 (big-endian)
mem_wdata  out  32  lane-replicated store data
mem_ready  in  1  memory accepts/completes the transfer this cycle
mem_rdata  in  32  read word, valid when mem_ready=1 on a read
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = operation failed
err_cause  out  2  00 none, 01 misaligned, 10 illegal opcode, 11 timeout
load_data  out  32  extended load result; updates only on a successful load

Behaviour:
- Reset values:
  - State IDLE.
  - mem_req, mem_we, done, err, busy = 0.
  - err_cause = 00.
  - mem_addr, mem_wstrb, mem_wdata, load_data = 0.
  - Timeout counter = 0.
- Reset mid-transaction drops mem_req asynchronously; no done is produced.
- Opcodes:
  - lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101.
  - sb 101000, sh 101001, sw 101011.
  - Any other opcode is illegal.
- FSM states: IDLE, REQ, DONE.
- IDLE, start=1: register opcode, addr and store_data, then check in this order:
  - Illegal opcode -> DONE with err=1, cause 10.
  - Misaligned -> DONE with err=1, cause 01. Misaligned means halfword op with addr[0]=1, or word op with addr[1:0]!=0. No memory request is issued.
  - Otherwise -> REQ.
- start while busy is ignored; it is not queued.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_wstrb and mem_wdata are held stable for the whole state.
  - mem_ready=1 at an edge: transfer completes -> DONE. For loads, load_data is captured at that same edge.
  - mem_ready while mem_req=0 is ignored.
- Timeout (TIMEOUT_CYCLES=N>0):
  - Counter clears on REQ entry and increments each REQ cycle without ready.
  - If the N-th REQ cycle also lacks ready -> DONE with err=1, cause 11. mem_req is low from the next cycle.
  - Ready in the N-th cycle wins over timeout.
- DONE: done=1 for exactly one cycle; err/err_cause are valid that cycle and 0 otherwise. Always returns to IDLE.
- Latency:
  - Start in cycle 0 -> mem_req in cycle 1.
  - Ready in cycle 1 -> done in cycle 2.
  - Next start is accepted in cycle 3.
  - Error without memory access -> done in cycle 1.
- Store steering (k = addr[1:0]):
  - sb: wstrb = 4'b1000>>k, wdata = {4{store_data[7:0]}}.
  - sh: wstrb = 1100 (k=0) or 0011 (k=2), wdata = {2{store_data[15:0]}}.
  - sw: wstrb = 1111, wdata = store_data.
  - Loads: wstrb = 0000, mem_we = 0.
- Load extract (big-endian):
  - Byte = mem_rdata[31-8k -: 8]; half = mem_rdata[31-8k -: 16] (k in {0,2}).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Failed loads and all stores leave load_data unchanged.

Decomposition:
- Package mips_ls_pkg:
  - Opcode localparams (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - err_cause encodings.
  - FSM state encoding.
  - Size enum (BYTE, HALF, WORD).
- Sub-module ls_lane_align: purely combinational.
  - Inputs: size, sign, offset, store_data, mem_rdata.
  - Outputs: wstrb, wdata, extended load value.
  - Reused later for the fetch/IO ports.
- Top module holds the FSM, timeout counter and registered outputs.

Test Plan:
- sw addr=0x100, store_data=0xDEADBEEF, ready in the first REQ cycle -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, done in cycle 2, err=0.
- sb addr=0x203, data=0x000000A5 -> mem_addr=0x200, wstrb=0001, wdata=0xA5A5A5A5. Repeat for offsets 0..2 -> strobes 1000/0100/0010.
- lb addr=0x101, mem_rdata=0x12F45678 -> load_data=0xFFFFFFF4; lbu -> 0x000000F4; lh addr=0x102 -> 0x00005678.
- lw addr=0x102 -> no mem_req, done in cycle 1, err=1, cause 01. Opcode 000000 -> cause 10. load_data is unchanged in both cases.
- TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req high exactly 4 cycles, then done with cause 11. Variant with ready in the 4th cycle -> success.
- Assert reset during REQ -> mem_req falls without a clock edge, no done pulse, next start works normally. start pulses during REQ are ignored.

Source files
------------

// File: rtl/mips_ls_pkg.sv
// Shared definitions for the load/store unit: MIPS memory opcodes, error
// cause encodings, FSM state encoding, access size and opcode decode helpers.
package mips_ls_pkg;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef struct packed {
    logic  legal;
    logic  store;
    logic  sign;
    size_t size;
  } op_info_t;

  // Classify a memory opcode; anything outside the eight listed ops is illegal.
  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t d;
    d.legal = 1'b1;
    d.store = 1'b0;
    d.sign  = 1'b0;
    d.size  = WORD;
    case (op)
      LB:      begin d.size = BYTE; d.sign = 1'b1; end
      LH:      begin d.size = HALF; d.sign = 1'b1; end
      LW:      d.size = WORD;
      LBU:     d.size = BYTE;
      LHU:     d.size = HALF;
      SB:      begin d.size = BYTE; d.store = 1'b1; end
      SH:      begin d.size = HALF; d.store = 1'b1; end
      SW:      begin d.size = WORD; d.store = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Natural alignment check on the byte offset within the word.
  function automatic logic is_misaligned(input size_t s, input logic [1:0] off);
    logic m;
    case (s)
      HALF:    m = off[0];
      WORD:    m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data memory port with a request/ready handshake.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/ls_lane_align.sv
// Big-endian lane steering: byte strobes and replicated write data for
// stores, lane extraction plus sign/zero extension for loads. Offset 0 is
// the most significant byte (bits 31:24).
module ls_lane_align
  import mips_ls_pkg::*;
(
  input  size_t       size,
  input  logic        sign,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_value
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Select the addressed byte and halfword from the read word.
  always_comb begin
    lane_byte = mem_rdata[31:24];
    case (offset)
      2'd0: lane_byte = mem_rdata[31:24];
      2'd1: lane_byte = mem_rdata[23:16];
      2'd2: lane_byte = mem_rdata[15:8];
      2'd3: lane_byte = mem_rdata[7:0];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = offset[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  // Strobe, write data replication and load extension by access size.
  always_comb begin
    wstrb      = 4'b1111;
    wdata      = store_data;
    load_value = mem_rdata;
    case (size)
      BYTE: begin
        wstrb      = 4'b1000 >> offset;
        wdata      = {4{store_data[7:0]}};
        load_value = {{24{sign & lane_byte[7]}}, lane_byte};
      end
      HALF: begin
        wstrb      = offset[1] ? 4'b0011 : 4'b1100;
        wdata      = {2{store_data[15:0]}};
        load_value = {{16{sign & lane_half[15]}}, lane_half};
      end
      default: begin
        wstrb      = 4'b1111;
        wdata      = store_data;
        load_value = mem_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory instruction, checks opcode and
// alignment, runs a single request/ready transfer with optional timeout and
// reports completion with a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; request registers hold the last access
//   REQ   | mem_req high, waiting for mem_ready or timeout
//   DONE  | done pulse; err/err_cause valid this cycle only
module load_store_unit
  import mips_ls_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [5:0]                opcode,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  load_store_unit_if.master         mem,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_cause,
  output logic [31:0]               load_data
);

  // Cast of TIMEOUT_CYCLES-1 wraps when the timeout is disabled; the
  // enable term below keeps that value from ever being compared.
  localparam logic [CNT_W-1:0] TC_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t           state, state_nxt;
  op_info_t         info_in;
  logic             misaligned;

  logic             store_q;
  logic             sign_q;
  size_t            size_q;
  logic [1:0]       offset_q;
  logic [31:0]      addr_q;
  logic [31:0]      store_data_q;
  logic             err_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             accept;
  logic             finish;
  logic             finish_err;
  logic [1:0]       finish_cause;
  logic             load_cap;
  logic             timeout_hit;

  logic [3:0]       lane_wstrb;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_load;

  assign info_in     = decode_op(opcode);
  assign misaligned  = is_misaligned(info_in.size, addr[1:0]);
  assign timeout_hit = TIMEOUT_EN && (cnt == TC_LAST);

  ls_lane_align u_align (
    .size       (size_q),
    .sign       (sign_q),
    .offset     (offset_q),
    .store_data (store_data_q),
    .mem_rdata  (mem.mem_rdata),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .load_value (lane_load)
  );

  // Next-state logic with transfer, error and counter control.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    accept       = 1'b0;
    finish       = 1'b0;
    finish_err   = 1'b0;
    finish_cause = CAUSE_NONE;
    load_cap     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (!info_in.legal) begin
            state_nxt    = DONE;
            finish       = 1'b1;
            finish_err   = 1'b1;
            finish_cause = CAUSE_ILLEGAL;
          end else if (misaligned) begin
            state_nxt    = DONE;
            finish       = 1'b1;
            finish_err   = 1'b1;
            finish_cause = CAUSE_MISALIGN;
          end else begin
            state_nxt = REQ;
            cnt_nxt   = '0;
          end
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          state_nxt = DONE;
          finish    = 1'b1;
          load_cap  = !store_q;
        end else if (timeout_hit) begin
          state_nxt    = DONE;
          finish       = 1'b1;
          finish_err   = 1'b1;
          finish_cause = CAUSE_TIMEOUT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request registers, captured once on accept and held through REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q      <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= BYTE;
      offset_q     <= 2'b00;
      addr_q       <= '0;
      store_data_q <= '0;
    end else if (accept) begin
      store_q      <= info_in.store;
      sign_q       <= info_in.sign;
      size_q       <= info_in.size;
      offset_q     <= addr[1:0];
      addr_q       <= {addr[31:2], 2'b00};
      store_data_q <= store_data;
    end
  end

  // Completion status, timeout counter and load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q     <= 1'b0;
      cause_q   <= CAUSE_NONE;
      cnt       <= '0;
      load_data <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (finish) begin
        err_q   <= finish_err;
        cause_q <= finish_cause;
      end
      if (load_cap) load_data <= lane_load;
    end
  end

  assign mem.mem_req   = (state == REQ);
  assign mem.mem_we    = store_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wstrb = store_q ? lane_wstrb : 4'b0000;
  assign mem.mem_wdata = lane_wdata;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = done & err_q;
  assign err_cause = done ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by
// random operations, compared against a byte-arithmetic reference model.
module tb_load_store_unit;
  import mips_ls_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, err;
  logic [1:0]  err_cause;
  logic [31:0] load_data;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .addr       (addr),
    .store_data (store_data),
    .mem        (mem_bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_cause  (err_cause),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] ld_model = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete operation. ready_at is the REQ cycle (1-based) in which
  // mem_ready is raised; 0 means never.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input int ready_at, input logic [31:0] rd);
    int          nb, k;
    bit          legal, st, sgn, mis, tmo, x_err;
    logic [1:0]  x_cause;
    logic [3:0]  x_strb;
    logic [31:0] x_wdata, x_load, mask;

    legal = 1; st = 0; sgn = 0; nb = 4;
    case (op)
      6'b100000: begin nb = 1; sgn = 1; end
      6'b100001: begin nb = 2; sgn = 1; end
      6'b100011: nb = 4;
      6'b100100: nb = 1;
      6'b100101: nb = 2;
      6'b101000: begin nb = 1; st = 1; end
      6'b101001: begin nb = 2; st = 1; end
      6'b101011: begin nb = 4; st = 1; end
      default:   legal = 0;
    endcase
    k       = int'(a % 4);
    mis     = legal && ((a % nb) != 0);
    tmo     = legal && !mis && (ready_at == 0 || ready_at > TO);
    x_err   = !legal || mis || tmo;
    x_cause = !legal ? 2'd2 : mis ? 2'd1 : tmo ? 2'd3 : 2'd0;
    x_strb  = !st ? 4'b0000 : (nb == 1) ? (4'b0001 << (3 - k))
            : (nb == 2) ? (4'b0011 << (2 - k)) : 4'b1111;
    x_wdata = (nb == 1) ? sd[7:0] * 32'h01010101
            : (nb == 2) ? sd[15:0] * 32'h00010001 : sd;
    x_load  = '0;
    if (legal && !mis) begin
      mask   = (nb == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nb)) - 32'd1);
      x_load = (rd >> (8 * (4 - nb - k))) & mask;
      if (sgn && x_load[8 * nb - 1]) x_load = x_load | ~mask;
    end

    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    start      = 1'b1;
    opcode     = op;
    addr       = a;
    store_data = sd;
    mem_bus.mem_ready = 1'($urandom_range(0, 1));
    mem_bus.mem_rdata = $urandom;
    @(negedge clk);
    start = 1'b0;
    mem_bus.mem_ready = 1'b0;

    if (!legal || mis) begin
      check("nomem_req", mem_bus.mem_req, 0);
    end else begin
      for (int n = 1; n <= TO; n++) begin
        check("req_high", mem_bus.mem_req, 1);
        check("req_done", done, 0);
        check("req_addr", mem_bus.mem_addr, {a[31:2], 2'b00});
        check("req_we", mem_bus.mem_we, st);
        check("req_wstrb", mem_bus.mem_wstrb, x_strb);
        if (st) check("req_wdata", mem_bus.mem_wdata, x_wdata);
        if (n == ready_at) begin
          mem_bus.mem_ready = 1'b1;
          mem_bus.mem_rdata = rd;
        end else begin
          mem_bus.mem_rdata = $urandom;
        end
        start  = 1'($urandom_range(0, 1));
        opcode = 6'($urandom);
        addr   = $urandom;
        @(negedge clk);
        mem_bus.mem_ready = 1'b0;
        start = 1'b0;
        if (n == ready_at || n == TO) break;
      end
      check("done_req_low", mem_bus.mem_req, 0);
    end
    check("done_pulse", done, 1);
    check("done_err", err, x_err);
    check("done_cause", err_cause, x_cause);
    if (!x_err && !st) ld_model = x_load;
    check("load_data", load_data, ld_model);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;

    #1;
    check("rst_req", mem_bus.mem_req, 0);
    check("rst_we", mem_bus.mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cause", err_cause, 0);
    check("rst_addr", mem_bus.mem_addr, 0);
    check("rst_wstrb", mem_bus.mem_wstrb, 0);
    check("rst_wdata", mem_bus.mem_wdata, 0);
    check("rst_load", load_data, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(SW, 32'h00000100, 32'hDEADBEEF, 1, 32'h0);
    run_op(SB, 32'h00000203, 32'h000000A5, 1, 32'h0);
    run_op(SB, 32'h00000200, 32'h000000A5, 2, 32'h0);
    run_op(SB, 32'h00000201, 32'h000000A5, 1, 32'h0);
    run_op(SB, 32'h00000202, 32'h000000A5, 3, 32'h0);
    run_op(SH, 32'h00000302, 32'h1234BEEF, 1, 32'h0);
    run_op(LB, 32'h00000101, 32'h0, 1, 32'h12F45678);
    run_op(LBU, 32'h00000101, 32'h0, 2, 32'h12F45678);
    run_op(LH, 32'h00000102, 32'h0, 1, 32'h12F45678);
    run_op(LH, 32'h00000100, 32'h0, 1, 32'h8001_0000);
    run_op(LW, 32'h00000102, 32'h0, 1, 32'hCAFEF00D);
    run_op(6'b000000, 32'h00000100, 32'h0, 1, 32'hCAFEF00D);
    run_op(SH, 32'h00000101, 32'h0, 1, 32'h0);
    run_op(SW, 32'h00000400, 32'h01020304, 0, 32'h0);
    run_op(LW, 32'h00000404, 32'h0, TO, 32'h89ABCDEF);
    run_op(LW, 32'h00000408, 32'h0, 0, 32'h11111111);

    @(negedge clk);
    start = 1'b1; opcode = SW; addr = 32'h00000500; store_data = 32'h55AA55AA;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", mem_bus.mem_req, 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_req", mem_bus.mem_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    check("rst_no_done", done, 0);
    reset = 1'b0;
    ld_model = '0;
    check("rst_load_clr", load_data, 0);
    run_op(LHU, 32'h00000502, 32'h0, 1, 32'hABCD9876);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] ops [8];
      logic [5:0] op;
      int         sel;
      ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
      sel = $urandom_range(0, 8);
      op  = (sel == 8) ? 6'($urandom) : ops[sel];
      run_op(op, $urandom, $urandom, $urandom_range(0, TO + 1), $urandom);
    end

    @(negedge clk);
    check("end_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
